// File: rtl/conv_pkg.sv
// conv_pkg: shared constants, state encoding and tap helpers for conv_engine.
package conv_pkg;
  typedef enum logic [1:0] {IDLE, CONV, POOL, DONE} state_t;
  localparam int IMG_W = 64;
  localparam int POOL_W = 32;
  localparam logic [2:0] CSEL_NONE = 3'b000;
  localparam logic [2:0] CSEL_L0 = 3'b001;
  localparam logic [2:0] CSEL_L1 = 3'b011;
  localparam logic signed [19:0] BIAS = 20'sh01310;
  localparam logic signed [19:0] KERNEL [9] = '{
    20'sh0A89E, 20'sh092D5, 20'sh06D43,
    20'sh01004, 20'shF8F71, 20'shF6E54,
    20'shFA6D7, 20'shFC834, 20'shFAC19
  };
  function automatic logic [1:0] tap_r(input logic [3:0] k);
    return k >= 4'd6 ? 2'd2 : k >= 4'd3 ? 2'd1 : 2'd0;
  endfunction
  function automatic logic [1:0] tap_c(input logic [3:0] k);
    return 2'(k - {1'b0, tap_r(k), 1'b0} - {2'b0, tap_r(k)});
  endfunction
  function automatic logic signed [19:0] kernel(input logic [3:0] k);
    return k < 4'd9 ? KERNEL[k] : 20'sd0;
  endfunction
endpackage

// File: rtl/conv_mac.sv
// conv_mac: signed 20x20 multiply-accumulate with clear, bias, round-half-up and ReLU output.
module conv_mac
  import conv_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               en,
  input  logic signed [19:0] a_i,
  input  logic signed [19:0] b_i,
  output logic        [19:0] y_o
);
  logic signed [43:0] acc_q, acc_d;
  logic signed [39:0] prod;
  logic        [19:0] hi;
  assign prod = a_i * b_i;
  assign acc_d = clr ? '0 : en ? acc_q + {{4{prod[39]}}, prod} : acc_q;
  // adding 2^15 only ever carries into bit 16 when acc bit 15 is set
  assign hi = acc_q[35:16] + BIAS + {19'b0, acc_q[15]};
  assign y_o = hi[19] ? '0 : hi;
  always_ff @(posedge clk)
    if (rst) acc_q <= '0;
    else acc_q <= acc_d;
endmodule

// File: rtl/conv_engine.sv
// conv_engine: 3x3 zero-padded convolution + ReLU into layer 0, then 2x2 max-pool into layer 1.
module conv_engine
  import conv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        ready,
  output logic        busy,
  output logic [11:0] iaddr,
  input  logic [19:0] idata,
  output logic        crd,
  output logic [11:0] caddr_rd,
  input  logic [19:0] cdata_rd,
  output logic        cwr,
  output logic [11:0] caddr_wr,
  output logic [19:0] cdata_wr,
  output logic [2:0]  csel
);
  state_t state_q, state_d;
  logic [11:0] p_q, p_d, iaddr_q, iaddr_d, caddr_rd_q, caddr_rd_d, caddr_wr_q, caddr_wr_d;
  logic [3:0] t_q, t_d, tk_q, tk_d;
  logic tv_q, tv_d, busy_q, busy_d, crd_q, crd_d, cwr_q, cwr_d, mac_clr, tap_ok;
  logic [19:0] max_q, max_d, cdata_wr_q, cdata_wr_d, pool_max, mac_y;
  logic [2:0] csel_q, csel_d;
  logic [6:0] nr, nc;
  logic signed [19:0] k_w;

  assign nr = {1'b0, p_q[11:6]} + {5'b0, tap_r(t_q)} - 7'd1;
  assign nc = {1'b0, p_q[5:0]} + {5'b0, tap_c(t_q)} - 7'd1;
  // -1 and 64 both set bit 6, so bit 6 flags a padding tap
  assign tap_ok = t_q < 4'd9 && !nr[6] && !nc[6];
  assign pool_max = cdata_rd > max_q ? cdata_rd : max_q;
  assign k_w = kernel(tk_q);

  conv_mac u_mac (
    .clk(clk),
    .rst(reset),
    .clr(mac_clr),
    .en(tv_q),
    .a_i(idata),
    .b_i(k_w),
    .y_o(mac_y)
  );

  always_comb begin
    state_d = state_q;
    p_d = p_q;
    t_d = t_q;
    tv_d = 1'b0;
    tk_d = tk_q;
    max_d = max_q;
    busy_d = busy_q;
    iaddr_d = iaddr_q;
    crd_d = 1'b0;
    caddr_rd_d = caddr_rd_q;
    cwr_d = 1'b0;
    caddr_wr_d = caddr_wr_q;
    cdata_wr_d = cdata_wr_q;
    csel_d = csel_q;
    mac_clr = 1'b0;
    case (state_q)
      IDLE: begin
        mac_clr = 1'b1;
        if (ready) begin
          busy_d = 1'b1;
          state_d = CONV;
          p_d = '0;
          t_d = '0;
          csel_d = CSEL_L0;
        end
      end
      CONV: begin
        if (t_q != 4'd10) begin
          t_d = t_q + 4'd1;
          tv_d = tap_ok;
          tk_d = t_q;
          iaddr_d = tap_ok ? {nr[5:0], nc[5:0]} : iaddr_q;
        end else begin
          cwr_d = 1'b1;
          caddr_wr_d = p_q;
          cdata_wr_d = mac_y;
          mac_clr = 1'b1;
          t_d = '0;
          p_d = p_q + 12'd1;
          state_d = p_q == 12'(IMG_W * IMG_W - 1) ? POOL : CONV;
        end
      end
      POOL: begin
        csel_d = CSEL_L0;
        max_d = t_q == 4'd0 ? '0 : pool_max;
        if (t_q < 4'd4) begin
          crd_d = 1'b1;
          caddr_rd_d = {p_q[9:5], t_q[1], p_q[4:0], t_q[0]};
          t_d = t_q + 4'd1;
        end else begin
          cwr_d = 1'b1;
          caddr_wr_d = p_q;
          cdata_wr_d = pool_max;
          csel_d = CSEL_L1;
          t_d = '0;
          p_d = p_q + 12'd1;
          state_d = p_q == 12'(POOL_W * POOL_W - 1) ? DONE : POOL;
        end
      end
      default: begin
        busy_d = 1'b0;
        csel_d = CSEL_NONE;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk)
    if (reset) begin
      state_q <= IDLE;
      p_q <= '0;
      t_q <= '0;
      tv_q <= 1'b0;
      tk_q <= '0;
      max_q <= '0;
      busy_q <= 1'b0;
      iaddr_q <= '0;
      crd_q <= 1'b0;
      caddr_rd_q <= '0;
      cwr_q <= 1'b0;
      caddr_wr_q <= '0;
      cdata_wr_q <= '0;
      csel_q <= CSEL_NONE;
    end else begin
      state_q <= state_d;
      p_q <= p_d;
      t_q <= t_d;
      tv_q <= tv_d;
      tk_q <= tk_d;
      max_q <= max_d;
      busy_q <= busy_d;
      iaddr_q <= iaddr_d;
      crd_q <= crd_d;
      caddr_rd_q <= caddr_rd_d;
      cwr_q <= cwr_d;
      caddr_wr_q <= caddr_wr_d;
      cdata_wr_q <= cdata_wr_d;
      csel_q <= csel_d;
    end

  assign busy = busy_q;
  assign iaddr = iaddr_q;
  assign crd = crd_q;
  assign caddr_rd = caddr_rd_q;
  assign cwr = cwr_q;
  assign caddr_wr = caddr_wr_q;
  assign cdata_wr = cdata_wr_q;
  assign csel = csel_q;
endmodule

// File: tb/tb_conv_engine.sv
// tb_conv_engine: scoreboard bench for conv_engine with image ROM and result memory models.
module tb_conv_engine;
  logic clk = 1'b0, reset = 1'b1, ready = 1'b1;
  logic busy, crd, cwr;
  logic [11:0] iaddr, caddr_rd, caddr_wr;
  logic [19:0] idata, cdata_rd, cdata_wr;
  logic [2:0] csel;
  logic [19:0] img [4096];
  logic [19:0] l0 [4096];
  logic [19:0] l1 [1024];
  logic [19:0] l0m [4096];
  typedef struct packed {logic [2:0] sel; logic [11:0] addr; logic [19:0] data;} wr_t;
  wr_t sb[$];
  wr_t exp_w;
  int chk = 0, err = 0, wr_count = 0, cyc = 0;
  localparam logic [19:0] KERN [9] = '{20'h0A89E, 20'h092D5, 20'h06D43, 20'h01004, 20'hF8F71,
                                        20'hF6E54, 20'hFA6D7, 20'hFC834, 20'hFAC19};
  localparam logic [63:0] BIAS_TB = 64'h01310;

  always #5 clk = ~clk;

  conv_engine dut (
    .clk(clk), .reset(reset), .ready(ready), .busy(busy), .iaddr(iaddr), .idata(idata),
    .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd), .cwr(cwr), .caddr_wr(caddr_wr),
    .cdata_wr(cdata_wr), .csel(csel)
  );

  assign idata = busy ? img[iaddr] : 20'h0;
  assign cdata_rd = (crd && csel == 3'b001) ? l0[caddr_rd] : 20'h0;

  always @(posedge clk)
    if (cwr) begin
      if (csel == 3'b001) l0[caddr_wr] <= cdata_wr;
      else if (csel == 3'b011) l1[caddr_wr[9:0]] <= cdata_wr;
    end

  initial forever begin
    @(negedge clk);
    if (crd) begin
      chk++;
      assert (csel === 3'b001) else begin
        err++;
        $error("FAIL read_sel: observed %b expected 001", csel);
      end
    end
    if (cwr) begin
      wr_count++;
      chk++;
      assert (sb.size() != 0) else begin
        err++;
        $error("FAIL unexpected_write: observed sel %b addr %h data %h expected no write", csel, caddr_wr, cdata_wr);
      end
      if (sb.size() != 0) begin
        exp_w = sb.pop_front();
        chk++;
        assert ({csel, caddr_wr, cdata_wr} === exp_w) else begin
          err++;
          $error("FAIL write: observed sel %b addr %h data %h expected sel %b addr %h data %h",
                 csel, caddr_wr, cdata_wr, exp_w.sel, exp_w.addr, exp_w.data);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    chk++;
    assert (got === expv) else begin
      err++;
      $error("FAIL %s: observed %h expected %h", tag, got, expv);
    end
  endtask

  task automatic zero_block(input int r0, input int c0, input int n);
    for (int r = r0; r < r0 + n; r++)
      for (int c = c0; c < c0 + n; c++) img[r * 64 + c] = 20'h0;
  endtask

  task automatic push_expected();
    for (int r = 0; r < 64; r++)
      for (int c = 0; c < 64; c++) begin
        logic signed [63:0] acc;
        logic [63:0] s;
        logic [19:0] y;
        acc = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if (r + dr >= 0 && r + dr < 64 && c + dc >= 0 && c + dc < 64)
              acc += $signed(img[(r + dr) * 64 + c + dc]) * $signed(KERN[(dr + 1) * 3 + dc + 1]);
        s = acc + (BIAS_TB << 16) + 64'h8000;
        y = s[35] ? 20'h0 : s[35:16];
        l0m[r * 64 + c] = y;
        sb.push_back({3'b001, 12'(r * 64 + c), y});
      end
    for (int pr = 0; pr < 32; pr++)
      for (int pc = 0; pc < 32; pc++) begin
        logic [19:0] m;
        m = l0m[(2 * pr) * 64 + 2 * pc];
        if (l0m[(2 * pr) * 64 + 2 * pc + 1] > m) m = l0m[(2 * pr) * 64 + 2 * pc + 1];
        if (l0m[(2 * pr + 1) * 64 + 2 * pc] > m) m = l0m[(2 * pr + 1) * 64 + 2 * pc];
        if (l0m[(2 * pr + 1) * 64 + 2 * pc + 1] > m) m = l0m[(2 * pr + 1) * 64 + 2 * pc + 1];
        sb.push_back({3'b011, 12'(pr * 32 + pc), m});
      end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) img[i] = 20'($urandom);
    zero_block(0, 0, 3);
    zero_block(61, 61, 3);
    zero_block(10, 10, 5);
    zero_block(19, 19, 5);
    zero_block(40, 40, 5);
    img[0] = 20'h10000;
    img[4095] = 20'h10000;
    img[21 * 64 + 21] = 20'h08000;
    img[42 * 64 + 42] = 20'hF8000;
    push_expected();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("reset_outputs", 64'({busy, crd, cwr, csel, iaddr, caddr_rd, caddr_wr, cdata_wr}), 64'd0);
    end
    reset = 1'b0;
    for (int i = 0; i < 2 && !busy; i++) begin
      @(posedge clk); #1;
    end
    check("busy_rise", 64'(busy), 64'd1);
    ready = 1'b0;
    for (int i = 0; i < 3000 && wr_count < 30; i++) @(posedge clk);
    #1;
    check("conv_progress", 64'(wr_count >= 30), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort_outputs", 64'({busy, crd, cwr, csel, iaddr, caddr_rd, caddr_wr, cdata_wr}), 64'd0);
    reset = 1'b0;
    sb.delete();
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      check("idle_after_abort", 64'(busy), 64'd0);
    end
    push_expected();
    ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0;
    check("busy_start", 64'(busy), 64'd1);
    while (busy && cyc < 60000) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("busy_fall", 64'(busy), 64'd0);
    check("cycle_budget", 64'(cyc <= 4096 * 12 + 1024 * 6 + 4), 64'd1);
    check("all_written", 64'(sb.size()), 64'd0);
    check("l0_origin", 64'(l0[0]), 64'h00000);
    check("l0_1", 64'(l0[1]), 64'h02314);
    check("l0_64", 64'(l0[64]), 64'h0A5E5);
    check("l0_65", 64'(l0[65]), 64'h0BBAE);
    check("l1_0", 64'(l1[0]), 64'h0BBAE);
    check("l0_4095", 64'(l0[4095]), 64'h00000);
    check("l0_4094", 64'(l0[4094]), 64'h00000);
    check("l0_4030", 64'(l0[4030]), 64'h00000);
    check("l0_zero_region", 64'(l0[12 * 64 + 12]), 64'h01310);
    check("l1_zero_region", 64'(l1[6 * 32 + 6]), 64'h01310);
    check("l0_tie_pos", 64'(l0[22 * 64 + 21]), 64'h05C7B);
    check("l0_tie_neg_px", 64'(l0[42 * 64 + 42]), 64'h04B58);
    for (int i = 0; i < 3; i++) @(posedge clk);
    #1;
    check("no_restart", 64'(busy), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", chk, err);
    $finish;
  end
endmodule
